// File: rtl/calc_pkg.sv
// Shared calculator constants and the blink scheduler state encoding.
package calc_pkg;

  localparam int unsigned HALF_PERIOD_1_5HZ = 33_333_334;
  localparam int unsigned CNT_W             = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } blink_state_e;

endpackage

// File: rtl/blink_scheduler_if.sv
// Requester/scheduler bundle: level requests with per-requester payload, grant and blink outputs.
interface blink_scheduler_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DIGITS = 4
);

  logic [NREQ-1:0]        req;
  logic [NREQ*DIGITS-1:0] req_mask;
  logic [NREQ*4-1:0]      req_count;
  logic [NREQ-1:0]        gnt;
  logic [DIGITS-1:0]      blink_mask;
  logic                   tick;
  logic [NREQ-1:0]        done;

  modport master (
    output req, req_mask, req_count,
    input  gnt, blink_mask, tick, done
  );

  modport slave (
    input  req, req_mask, req_count,
    output gnt, blink_mask, tick, done
  );

endinterface

// File: rtl/blink_scheduler_phase_timer.sv
// Phase counter: counts 0..HALF_PERIOD-1 while enabled; tick is high on the terminal count.
module phase_timer #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Combinational so the FSM can change phase on the same edge the counter wraps.
  assign tick = en && !clr && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/blink_scheduler.sv
// Grants one requester the shared blink time base and drives its digit mask through blank/show phases.
// BLINK_SCHED_RR_EN selects round-robin arbitration; otherwise fixed priority, lowest index wins.
module blink_scheduler
  import calc_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = calc_pkg::HALF_PERIOD_1_5HZ,
  parameter int unsigned CNT_W       = calc_pkg::CNT_W,
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DIGITS      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  blink_scheduler_if.slave  bus
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  blink_state_e      state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [DIGITS-1:0] mask_q, mask_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DIGITS-1:0] blink_q, blink_d;
  logic              tick_q, tick_d;
  logic [NREQ-1:0]   done_q, done_d;

  logic [IDX_W-1:0]  win_idx;
  logic              win_vld;
  logic              abort_c;
  logic              tmr_tick;
  logic              tmr_clr;
  logic              tmr_en;

`ifdef BLINK_SCHED_RR_EN
  logic [IDX_W-1:0]  last_q, last_d;
  int unsigned       rr_idx;

  // Round-robin search starting just past the last grant.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    rr_idx  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rr_idx = (32'(last_q) + 32'(1) + i) % NREQ;
      if (!win_vld && bus.req[IDX_W'(rr_idx)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(rr_idx);
      end
    end
  end
`else
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!win_vld && bus.req[IDX_W'(i)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end
`endif

  assign abort_c = |(gnt_q & ~bus.req);
  assign tmr_en  = (state_q != IDLE);
  assign tmr_clr = (state_q == IDLE) || abort_c;

  phase_timer #(
    .HALF_PERIOD (HALF_PERIOD),
    .CNT_W       (CNT_W)
  ) u_phase_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tick  (tmr_tick)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    tick_d  = 1'b0;
    done_d  = '0;
`ifdef BLINK_SCHED_RR_EN
    last_d  = last_q;
`endif
    if (state_q != IDLE && abort_c) begin
      // A dropped request wins over any phase boundary in the same cycle.
      state_d = IDLE;
      gnt_d   = '0;
      blink_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            state_d = BLANK;
            gnt_d   = NREQ'(1) << win_idx;
            mask_d  = bus.req_mask[32'(win_idx)*DIGITS +: DIGITS];
            cnt_d   = bus.req_count[32'(win_idx)*4 +: 4];
            blink_d = bus.req_mask[32'(win_idx)*DIGITS +: DIGITS];
`ifdef BLINK_SCHED_RR_EN
            last_d  = win_idx;
`endif
          end
        end
        BLANK: begin
          if (tmr_tick) begin
            tick_d  = 1'b1;
            blink_d = '0;
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (tmr_tick) begin
            tick_d = 1'b1;
            if (cnt_q == 4'd1) begin
              done_d  = gnt_q;
              gnt_d   = '0;
              blink_d = '0;
              state_d = IDLE;
            end else begin
              // A count latched as zero means blink until the request drops.
              if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
              blink_d = mask_q;
              state_d = BLANK;
            end
          end
        end
        default: begin
          state_d = IDLE;
          gnt_d   = '0;
          blink_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      blink_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

`ifdef BLINK_SCHED_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= IDX_W'(NREQ - 1);
    else        last_q <= last_d;
  end
`endif

  assign bus.gnt        = gnt_q;
  assign bus.blink_mask = blink_q;
  assign bus.tick       = tick_q;
  assign bus.done       = done_q;

endmodule
